// File: rtl/mod_exp_if.sv
// rtl/mod_exp_if.sv - start/result and square/multiply operator bundle for mod_exp
// Ports (master = mod_exp controller, slave = requester plus responders):
//   ready_in, base_in, exponent_in, modulus_in   start strobe and operands
//   result_out, busy_out, valid_out               result and status
//   sq_ready_out, sq_value_out, sq_modulus_out    square request
//   sq_result_in, sq_valid_in                     square response
//   mul_ready_out, mul_a_out, mul_b_out,
//   mul_modulus_out                               multiply request
//   mul_result_in, mul_valid_in                   multiply response
interface mod_exp_if #(
  parameter int WIDTH     = 16,
  parameter int EXP_WIDTH = 16
);
  logic                 ready_in;
  logic [WIDTH-1:0]     base_in;
  logic [EXP_WIDTH-1:0] exponent_in;
  logic [WIDTH-1:0]     modulus_in;
  logic [WIDTH-1:0]     result_out;
  logic                 busy_out;
  logic                 valid_out;
  logic                 sq_ready_out;
  logic [WIDTH-1:0]     sq_value_out;
  logic [WIDTH-1:0]     sq_modulus_out;
  logic [WIDTH-1:0]     sq_result_in;
  logic                 sq_valid_in;
  logic                 mul_ready_out;
  logic [WIDTH-1:0]     mul_a_out;
  logic [WIDTH-1:0]     mul_b_out;
  logic [WIDTH-1:0]     mul_modulus_out;
  logic [WIDTH-1:0]     mul_result_in;
  logic                 mul_valid_in;

  modport master (
    input  ready_in, base_in, exponent_in, modulus_in,
    output result_out, busy_out, valid_out,
    output sq_ready_out, sq_value_out, sq_modulus_out,
    input  sq_result_in, sq_valid_in,
    output mul_ready_out, mul_a_out, mul_b_out, mul_modulus_out,
    input  mul_result_in, mul_valid_in
  );

  modport slave (
    output ready_in, base_in, exponent_in, modulus_in,
    input  result_out, busy_out, valid_out,
    input  sq_ready_out, sq_value_out, sq_modulus_out,
    output sq_result_in, sq_valid_in,
    input  mul_ready_out, mul_a_out, mul_b_out, mul_modulus_out,
    output mul_result_in, mul_valid_in
  );
endinterface

// File: rtl/mod_exp.sv
// rtl/mod_exp.sv - left-to-right square-and-multiply modular exponentiation controller
// Ports:
//   clk_in  clock, all state on rising edge
//   rst_in  synchronous active-high reset
//   bus     mod_exp_if.master: start/operands, result/busy/valid,
//           square and multiply request/response channels
module mod_exp #(
  parameter int WIDTH     = 16,
  parameter int EXP_WIDTH = 16
) (
  input  logic     clk_in,
  input  logic     rst_in,
  mod_exp_if.master bus
);
  localparam int CNT_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE, SQ_REQ, SQ_WAIT, MUL_REQ, MUL_WAIT, NEXT, DONE
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     acc_q, base_q, mod_q, result_q;
  logic [EXP_WIDTH-1:0] exp_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 busy_prev_q;
  logic                 busy;
  logic                 cur_bit;
  logic                 small_mod;

  assign cur_bit   = exp_q[cnt_q];
  // Modulus 1 (and illegal 0) has result 0 and needs no responder traffic.
  assign small_mod = (bus.modulus_in < WIDTH'(2));

  // Responders sample these continuously; they only move when acc_q is
  // written, which happens after the matching valid has been taken.
  assign bus.sq_value_out    = acc_q;
  assign bus.sq_modulus_out  = mod_q;
  assign bus.mul_a_out       = acc_q;
  assign bus.mul_b_out       = base_q;
  assign bus.mul_modulus_out = mod_q;
  assign bus.result_out      = result_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (bus.ready_in) state_d = small_mod ? DONE : SQ_REQ;
      SQ_REQ:   state_d = SQ_WAIT;
      SQ_WAIT:  if (bus.sq_valid_in) state_d = cur_bit ? MUL_REQ : NEXT;
      MUL_REQ:  state_d = MUL_WAIT;
      MUL_WAIT: if (bus.mul_valid_in) state_d = NEXT;
      NEXT:     state_d = (cnt_q == '0) ? DONE : SQ_REQ;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    busy              = (state_q != IDLE);
    bus.busy_out      = busy;
    bus.sq_ready_out  = (state_q == SQ_REQ);
    bus.mul_ready_out = (state_q == MUL_REQ);
    // Completion pulse on the first idle cycle after an operation.
    bus.valid_out     = busy_prev_q & ~busy;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      acc_q       <= '0;
      base_q      <= '0;
      mod_q       <= '0;
      exp_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      busy_prev_q <= 1'b0;
    end else begin
      busy_prev_q <= busy;
      case (state_q)
        IDLE: begin
          if (bus.ready_in) begin
            base_q <= bus.base_in;
            exp_q  <= bus.exponent_in;
            mod_q  <= bus.modulus_in;
            acc_q  <= small_mod ? '0 : WIDTH'(1);
            cnt_q  <= CNT_W'(EXP_WIDTH - 1);
          end
        end
        SQ_WAIT:  if (bus.sq_valid_in)  acc_q <= bus.sq_result_in;
        MUL_WAIT: if (bus.mul_valid_in) acc_q <= bus.mul_result_in;
        NEXT:     if (cnt_q != '0)      cnt_q <= cnt_q - CNT_W'(1);
        DONE:     result_q <= acc_q;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mod_exp.sv
// tb/tb_mod_exp.sv - self-checking bench for mod_exp with 3-cycle stub responders
module tb_mod_exp;
  localparam int W = 16;
  localparam int E = 16;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  mod_exp_if #(.WIDTH(W), .EXP_WIDTH(E)) bus ();

  mod_exp #(.WIDTH(W), .EXP_WIDTH(E)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Stub responders: valid rises three edges after the strobe edge.
  int         sq_cnt = 0, mul_cnt = 0;
  logic [W-1:0] sq_res = '0, mul_res = '0;
  logic       rsp_sq_valid = 1'b0, rsp_mul_valid = 1'b0;
  logic       stray_sq = 1'b0, stray_mul = 1'b0;
  int         sq_pulses = 0, mul_pulses = 0, valid_pulses = 0;

  assign bus.sq_valid_in   = rsp_sq_valid | stray_sq;
  assign bus.sq_result_in  = stray_sq ? 16'h1234 : sq_res;
  assign bus.mul_valid_in  = rsp_mul_valid | stray_mul;
  assign bus.mul_result_in = stray_mul ? 16'h4321 : mul_res;

  function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] m);
    longint p;
    if (m == 0) return '0;
    p = (longint'(a) * longint'(b)) % longint'(m);
    return W'(p);
  endfunction

  always @(posedge clk_in) begin
    rsp_sq_valid <= 1'b0;
    if (bus.sq_ready_out) begin
      sq_cnt    <= 3;
      sq_pulses <= sq_pulses + 1;
      sq_res    <= mulmod(bus.sq_value_out, bus.sq_value_out, bus.sq_modulus_out);
    end else if (sq_cnt == 1) begin
      rsp_sq_valid <= 1'b1;
      sq_cnt       <= 0;
    end else if (sq_cnt > 1) begin
      sq_cnt <= sq_cnt - 1;
    end
  end

  always @(posedge clk_in) begin
    rsp_mul_valid <= 1'b0;
    if (bus.mul_ready_out) begin
      mul_cnt    <= 3;
      mul_pulses <= mul_pulses + 1;
      mul_res    <= mulmod(bus.mul_a_out, bus.mul_b_out, bus.mul_modulus_out);
    end else if (mul_cnt == 1) begin
      rsp_mul_valid <= 1'b1;
      mul_cnt       <= 0;
    end else if (mul_cnt > 1) begin
      mul_cnt <= mul_cnt - 1;
    end
  end

  always @(posedge clk_in) if (bus.valid_out) valid_pulses <= valid_pulses + 1;

  // Reference: right-to-left exponentiation on plain integers.
  function automatic logic [W-1:0] ref_pow(input logic [W-1:0] b, input logic [E-1:0] e,
                                           input logic [W-1:0] m);
    longint r, x, mm;
    if (m < 2) return '0;
    mm = longint'(m);
    r  = 1;
    x  = longint'(b) % mm;
    for (int i = 0; i < E; i++) begin
      if (e[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return W'(r);
  endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // glitch: 0 none, 1 second ready_in mid-operation, 2 stray mul valid in SQ_WAIT
  task automatic run_op(input logic [W-1:0] b, input logic [E-1:0] e, input logic [W-1:0] m,
                        input int glitch, input string tag, output int lat);
    int   s0, m0, v0, n;
    logic done, arm, used;
    s0 = sq_pulses; m0 = mul_pulses; v0 = valid_pulses;
    @(negedge clk_in);
    bus.base_in = b; bus.exponent_in = e; bus.modulus_in = m; bus.ready_in = 1'b1;
    @(negedge clk_in);
    bus.ready_in = 1'b0;
    check({tag, "_busy_rise"}, bus.busy_out, 1);
    n = 0; done = 1'b0; arm = 1'b0; used = 1'b0;
    while (!done && n < 3000) begin
      if (bus.valid_out) done = 1'b1;
      else begin
        if (glitch == 1 && n == 20) begin
          bus.base_in = ~b; bus.exponent_in = ~e; bus.modulus_in = m ^ 16'h00F0;
          bus.ready_in = 1'b1;
        end
        if (glitch == 1 && n == 21) bus.ready_in = 1'b0;
        if (glitch == 2) begin
          if (stray_mul) stray_mul = 1'b0;
          else if (arm) begin stray_mul = 1'b1; arm = 1'b0; used = 1'b1; end
          else if (bus.sq_ready_out && !used) arm = 1'b1;
        end
        @(negedge clk_in);
        n++;
      end
    end
    stray_mul = 1'b0;
    lat = n + 2;  // cycle holding valid_out, counting the ready_in cycle as 1
    check({tag, "_done"}, done, 1);
    check({tag, "_result"}, bus.result_out, ref_pow(b, e, m));
    check({tag, "_busy_fall"}, bus.busy_out, 0);
    @(negedge clk_in);
    check({tag, "_valid_once"}, valid_pulses - v0, 1);
    check({tag, "_sq_reqs"}, sq_pulses - s0, (m < 2) ? 0 : E);
    check({tag, "_mul_reqs"}, mul_pulses - m0, (m < 2) ? 0 : $countones(e));
    check({tag, "_result_hold"}, bus.result_out, ref_pow(b, e, m));
  endtask

  initial begin
    int lat, v0, n;
    logic [W-1:0] r0, rb, rm;
    logic [E-1:0] re;
    bus.ready_in = 1'b0; bus.base_in = '0; bus.exponent_in = '0; bus.modulus_in = '0;

    repeat (3) @(negedge clk_in);
    check("rst_busy", bus.busy_out, 0);
    check("rst_valid", bus.valid_out, 0);
    check("rst_result", bus.result_out, 0);
    check("rst_sq_ready", bus.sq_ready_out, 0);
    check("rst_mul_ready", bus.mul_ready_out, 0);
    rst_in = 1'b0;

    run_op(16'd4, 16'd13, 16'd497, 0, "p4_13_497", lat);
    check("p4_13_497_value", bus.result_out, 445);
    run_op(16'd2, 16'd10, 16'd1000, 0, "p2_10_1000", lat);
    check("p2_10_1000_value", bus.result_out, 24);
    run_op(16'd3, 16'd0, 16'd7, 0, "p3_0_7", lat);
    check("p3_0_7_value", bus.result_out, 1);
    run_op(16'd1234, 16'hBEEF, 16'd1, 0, "mod1", lat);
    check("mod1_latency", lat, 3);
    run_op(16'd99, 16'd5, 16'd0, 0, "mod0", lat);
    run_op(16'd65535, 16'hFFFF, 16'd65535, 0, "max_ops", lat);

    run_op(16'd7, 16'h8001, 16'd9973, 1, "ready_midop", lat);
    run_op(16'd11, 16'hA5A5, 16'd4093, 2, "stray_mul", lat);

    // Stray square valid while idle
    r0 = bus.result_out; v0 = valid_pulses;
    @(negedge clk_in); stray_sq = 1'b1;
    @(negedge clk_in); stray_sq = 1'b0;
    check("stray_sq_busy", bus.busy_out, 0);
    @(negedge clk_in);
    check("stray_sq_result", bus.result_out, r0);
    check("stray_sq_valid", valid_pulses - v0, 0);

    // Reset while waiting on a multiply
    @(negedge clk_in);
    bus.base_in = 16'd5; bus.exponent_in = 16'hFFFF; bus.modulus_in = 16'd1009;
    bus.ready_in = 1'b1;
    @(negedge clk_in); bus.ready_in = 1'b0;
    n = 0;
    while (!bus.mul_ready_out && n < 200) begin @(negedge clk_in); n++; end
    check("rst_mul_seen", bus.mul_ready_out, 1);
    @(negedge clk_in);
    v0 = valid_pulses;
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    check("midrst_busy", bus.busy_out, 0);
    check("midrst_valid", bus.valid_out, 0);
    check("midrst_result", bus.result_out, 0);
    check("midrst_sq_ready", bus.sq_ready_out, 0);
    check("midrst_mul_ready", bus.mul_ready_out, 0);
    check("midrst_sq_value", bus.sq_value_out, 0);
    check("midrst_sq_mod", bus.sq_modulus_out, 0);
    check("midrst_mul_a", bus.mul_a_out, 0);
    check("midrst_mul_b", bus.mul_b_out, 0);
    check("midrst_mul_mod", bus.mul_modulus_out, 0);
    repeat (8) @(negedge clk_in);
    check("midrst_late_busy", bus.busy_out, 0);
    check("midrst_late_valid", valid_pulses - v0, 0);
    check("midrst_late_result", bus.result_out, 0);
    run_op(16'd5, 16'hFFFF, 16'd1009, 0, "after_rst", lat);

    for (int i = 0; i < 6; i++) begin
      rb = W'($urandom);
      re = E'($urandom);
      rm = W'($urandom_range(2, 65535));
      run_op(rb, re, rm, 0, $sformatf("rand%0d", i), lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
